// File: rtl/alu_pkg.sv
// Shared types and defaults for the serial Hack-style ALU.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 16;
  localparam int unsigned ALU_SLICE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } ctrl_t;

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit Hack ALU datapath with carry in/out.
module alu_slice
  import alu_pkg::*;
#(
  parameter int unsigned SLICE = ALU_SLICE
) (
  input  logic [SLICE-1:0] x_i,
  input  logic [SLICE-1:0] y_i,
  input  ctrl_t            ctrl_i,
  input  logic             cin_i,
  output logic [SLICE-1:0] out_o,
  output logic             cout_o
);

  logic [SLICE-1:0] x3_s;
  logic [SLICE-1:0] y3_s;
  logic [SLICE-1:0] o_s;
  logic [SLICE:0]   sum_s;

  // Preset, add-or-and, then optional output negation.
  always_comb begin
    x3_s  = ctrl_i.zx ? {SLICE{ctrl_i.nx}} : (x_i ^ {SLICE{ctrl_i.nx}});
    y3_s  = ctrl_i.zy ? {SLICE{ctrl_i.ny}} : (y_i ^ {SLICE{ctrl_i.ny}});
    sum_s = {1'b0, x3_s} + {1'b0, y3_s} + {{SLICE{1'b0}}, cin_i};
    if (ctrl_i.f) begin
      o_s    = sum_s[SLICE-1:0];
      cout_o = sum_s[SLICE];
    end else begin
      o_s    = x3_s & y3_s;
      cout_o = 1'b0;
    end
    out_o = o_s ^ {SLICE{ctrl_i.no}};
  end

endmodule

// File: rtl/alu_serial.sv
// Bit-serial (slice-per-cycle) Hack ALU with valid/ready handshakes on both sides.
module alu_serial
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned SLICE = ALU_SLICE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cout
);

  localparam int unsigned NSL = WIDTH / SLICE;
  localparam int unsigned KW  = (NSL > 1) ? $clog2(NSL) : 1;

  state_t           state_q;
  ctrl_t            ctrl_q;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] out_q;
  logic [KW-1:0]    k_q;
  logic             carry_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             zr_q;
  logic             ng_q;
  logic             cout_q;

  logic [SLICE-1:0] slice_x_d;
  logic [SLICE-1:0] slice_y_d;
  logic [SLICE-1:0] slice_o_d;
  logic             slice_c_d;
  logic [WIDTH-1:0] res_d;

  // Select the active operand slice and merge its result into the running word.
  always_comb begin
    slice_x_d = x_q[k_q*SLICE +: SLICE];
    slice_y_d = y_q[k_q*SLICE +: SLICE];
    res_d     = out_q;
    res_d[k_q*SLICE +: SLICE] = slice_o_d;
  end

  alu_slice #(.SLICE(SLICE)) u_slice (
    .x_i    (slice_x_d),
    .y_i    (slice_y_d),
    .ctrl_i (ctrl_q),
    .cin_i  (carry_q),
    .out_o  (slice_o_d),
    .cout_o (slice_c_d)
  );

  // Control FSM and datapath registers; flags are taken from the merged word on the final slice.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ctrl_q      <= 6'b000000;
      x_q         <= {WIDTH{1'b0}};
      y_q         <= {WIDTH{1'b0}};
      out_q       <= {WIDTH{1'b0}};
      k_q         <= {KW{1'b0}};
      carry_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      zr_q        <= 1'b0;
      ng_q        <= 1'b0;
      cout_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            x_q        <= x;
            y_q        <= y;
            ctrl_q     <= {zx, nx, zy, ny, f, no};
            out_q      <= {WIDTH{1'b0}};
            k_q        <= {KW{1'b0}};
            carry_q    <= 1'b0;
            zr_q       <= 1'b0;
            ng_q       <= 1'b0;
            cout_q     <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        RUN: begin
          out_q   <= res_d;
          carry_q <= slice_c_d;
          k_q     <= k_q + {{(KW-1){1'b0}}, 1'b1};
          if (k_q == KW'(NSL - 1)) begin
            zr_q        <= (res_d == {WIDTH{1'b0}});
            ng_q        <= res_d[WIDTH-1];
            cout_q      <= slice_c_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            state_q <= RUN;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end else begin
            state_q <= DONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign zr        = zr_q;
  assign ng        = ng_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_alu_serial.sv
// Self-checking bench for alu_serial (WIDTH=16, SLICE=4) against a word-level Hack ALU model.
module tb_alu_serial;

  localparam int W   = 16;
  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] x, y, out;
  logic         zx, nx, zy, ny, f, no, zr, ng, cout;

  int errors = 0;
  int checks = 0;

  alu_serial #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .zr(zr), .ng(ng), .cout(cout)
  );

  always #5 clk = ~clk;

  // c = {zx,nx,zy,ny,f,no}; returns {cout, out}
  function automatic logic [W:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [5:0] c);
    logic [W-1:0] a3, b3, o;
    logic [W:0]   s;
    logic         co;
    a3 = c[5] ? (c[4] ? 16'hFFFF : 16'h0000) : (c[4] ? ~a : a);
    b3 = c[3] ? (c[2] ? 16'hFFFF : 16'h0000) : (c[2] ? ~b : b);
    if (c[1]) begin
      s  = {1'b0, a3} + {1'b0, b3};
      o  = s[W-1:0];
      co = s[W];
    end else begin
      o  = a3 & b3;
      co = 1'b0;
    end
    if (c[0]) o = ~o;
    return {co, o};
  endfunction

  task automatic drive_ctrl(input logic [5:0] c);
    {zx, nx, zy, ny, f, no} = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, scramble the inputs afterwards, and wait (bounded) for out_valid.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] c,
                        output int lat);
    int n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    x = a; y = b; drive_ctrl(c); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    x = 16'($urandom); y = 16'($urandom); drive_ctrl(6'($urandom));
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; x = 16'hFFFF; y = 16'hFFFF;
    drive_ctrl(6'b000010);
    tick(); tick();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if ({out, zr, ng, cout} !== 19'd0) begin errors++;
      $display("FAIL reset_out got out=%h zr=%b ng=%b cout=%b want all 0", out, zr, ng, cout); end
  endtask

  task automatic test_directed();
    logic [W-1:0] tx [5] = '{16'h1234, 16'h5A5A, 16'h0005, 16'hFFFF, 16'h00FF};
    logic [W-1:0] ty [5] = '{16'h0F0F, 16'hA5A5, 16'h0005, 16'h0001, 16'hFF00};
    logic [5:0]   tc [5] = '{6'b000010, 6'b111010, 6'b010011, 6'b000010, 6'b000000};
    logic [W-1:0] eo [5] = '{16'h2143, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
    logic [2:0]   ef [5] = '{3'b000, 3'b010, 3'b100, 3'b101, 3'b100}; // {zr,ng,cout}
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(tx[i], ty[i], tc[i], lat);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, LAT); end
      checks++; if (out !== eo[i]) begin errors++; $display("FAIL dir%0d_out got=%h want=%h", i, out, eo[i]); end
      checks++; if ({zr, ng, cout} !== ef[i]) begin errors++;
        $display("FAIL dir%0d_flags got zr/ng/cout=%b want=%b", i, {zr, ng, cout}, ef[i]); end
      handshake();
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic [5:0]   c;
    logic [W:0]   e;
    int lat;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom); b = 16'($urandom); c = 6'($urandom);
      if (i % 4 == 0) b = -a;
      e = ref_alu(a, b, c);
      run_op(a, b, c, lat);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL rnd%0d_latency got=%0d want=%0d", i, lat, LAT); end
      checks++; if ({cout, out} !== e) begin errors++;
        $display("FAIL rnd%0d_result a=%h b=%h c=%b got cout/out=%b/%h want=%b/%h", i, a, b, c, cout, out, e[W], e[W-1:0]); end
      checks++; if ({zr, ng} !== {(e[W-1:0] == 16'h0000), e[W-1]}) begin errors++;
        $display("FAIL rnd%0d_flags got zr/ng=%b%b want=%b%b", i, zr, ng, (e[W-1:0] == 16'h0000), e[W-1]); end
      repeat ($urandom_range(0, 2)) tick();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rnd%0d_busy_in_ready got=%b want=0", i, in_ready); end
      handshake();
    end
  endtask

  task automatic test_back_to_back();
    logic [W:0] e;
    int lat;
    for (int i = 0; i < 3; i++) begin
      e = ref_alu(16'h1000 * i[15:0] + 16'h0123, 16'hF00F, 6'b000010);
      run_op(16'h1000 * i[15:0] + 16'h0123, 16'hF00F, 6'b000010, lat);
      checks++; if (lat !== LAT || {cout, out} !== e) begin errors++;
        $display("FAIL b2b%0d got lat=%0d cout/out=%b/%h want lat=%0d %b/%h", i, lat, cout, out, LAT, e[W], e[W-1:0]); end
      handshake();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b%0d_ready got=%b want=1", i, in_ready); end
    end
  endtask

  task automatic test_backpressure();
    logic [W+2:0] held;
    int lat;
    run_op(16'h1234, 16'h0F0F, 6'b000010, lat);
    held = {out, zr, ng, cout};
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; x = 16'($urandom); y = 16'($urandom);
      tick();
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++;
        $display("FAIL bp%0d_hs got out_valid=%b in_ready=%b want 1/0", i, out_valid, in_ready); end
      checks++; if ({out, zr, ng, cout} !== held) begin errors++;
        $display("FAIL bp%0d_hold got=%h want=%h", i, {out, zr, ng, cout}, held); end
    end
    handshake();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL bp_release got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_run();
    int lat, seen;
    x = 16'hAAAA; y = 16'h5555; drive_ctrl(6'b000010); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
      $display("FAIL rst_mid got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    seen = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (out_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_no_result got=%0d valid cycles want=0", seen); end
    run_op(16'h00FF, 16'hFF00, 6'b000000, lat);
    checks++; if (lat !== LAT || out !== 16'h0000 || zr !== 1'b1) begin errors++;
      $display("FAIL rst_mid_next got lat=%0d out=%h zr=%b want %0d/0000/1", lat, out, zr, LAT); end
    handshake();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0; drive_ctrl(6'b000000);
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
